// File: rtl/countgen_pkg.sv
// Shared types and constants for the countgen scheduler slice.
package countgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT,
    ST_PUBLISH
  } state_e;

  localparam int PERIOD_W    = 32;
  localparam int DEF_SETTLE  = 4;
  localparam int DEF_TIMEOUT = 1048576;

endpackage

// File: rtl/countgen_rr_pick.sv
// Round-robin picker: nearest set mask bit strictly after `last`, with wrap.
module countgen_rr_pick #(
  parameter  int CHANNELS = 4,
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] mask,
  input  logic [IW-1:0]       last,
  output logic [IW-1:0]       next,
  output logic                any
);

  logic [IW-1:0] idx;

  // Scan farthest to nearest so the nearest hit is written last.
  always_comb begin
    next = '0;
    idx  = '0;
    any  = |mask;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % CHANNELS);
      if (mask[idx]) next = idx;
    end
  end

endmodule

// File: rtl/countgen_scheduler.sv
// Time-shares one countgen_counter across CHANNELS inputs, round-robin.
// Define COUNTGEN_SCHED_TIMEOUT_EN to enable the WAIT timeout.
module countgen_scheduler
  import countgen_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int SETTLE   = DEF_SETTLE,
  parameter  int TIMEOUT  = DEF_TIMEOUT,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] chan_mask,
  input  logic [CHANNELS-1:0] in,
  output logic                cnt_in,
  output logic                cnt_rst,
  input  logic [PERIOD_W-1:0] cnt_period,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PERIOD_W-1:0] res_period,
  output logic [CW-1:0]       res_chan,
  output logic                res_timeout,
  output logic                busy
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       sel_q, sel_d;
  logic [CW-1:0]       last_q, last_d;
  logic [SW-1:0]       set_cnt_q, set_cnt_d;
  logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic                tmo_q, tmo_d;
  logic [CW-1:0]       pick;
  logic                pick_any;
  logic                start;
  logic                tmo_hit;

  countgen_rr_pick #(
    .CHANNELS(CHANNELS)
  ) u_pick (
    .mask(chan_mask),
    .last(last_q),
    .next(pick),
    .any (pick_any)
  );

  assign start = en && pick_any;

`ifdef COUNTGEN_SCHED_TIMEOUT_EN
  assign tmo_hit = (wait_cnt_q >= WW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    set_cnt_d  = set_cnt_q;
    wait_cnt_d = wait_cnt_q;
    period_d   = period_q;
    chan_d     = chan_q;
    tmo_d      = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (set_cnt_q == SW'(SETTLE - 1)) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
        // A real period beats a same-cycle timeout.
        if (cnt_period != '0) begin
          state_d  = ST_PUBLISH;
          period_d = cnt_period;
          chan_d   = sel_q;
          tmo_d    = 1'b0;
        end else if (tmo_hit) begin
          state_d  = ST_PUBLISH;
          period_d = '0;
          chan_d   = sel_q;
          tmo_d    = 1'b1;
        end
      end
      ST_PUBLISH: begin
        if (res_ready) state_d = start ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_SETTLE && state_q != ST_SETTLE) begin
      sel_d     = pick;
      last_d    = pick;
      set_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      last_q     <= CW'(CHANNELS - 1);
      set_cnt_q  <= '0;
      wait_cnt_q <= '0;
      period_q   <= '0;
      chan_q     <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      set_cnt_q  <= set_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      period_q   <= period_d;
      chan_q     <= chan_d;
      tmo_q      <= tmo_d;
    end
  end

  assign cnt_in      = in[sel_q];
  assign cnt_rst     = rst || (state_q != ST_WAIT);
  assign busy        = !rst && (state_q != ST_IDLE);
  assign res_valid   = !rst && (state_q == ST_PUBLISH);
  assign res_period  = period_q;
  assign res_chan    = chan_q;
  assign res_timeout = tmo_q;

endmodule

// File: tb/tb_countgen_scheduler.sv
// Directed bench for countgen_scheduler with a behavioural period counter.
module tb_countgen_scheduler;

  logic        clk = 1'b0;
  logic        rst, en, res_ready;
  logic [3:0]  chan_mask, in_sig;
  logic        cnt_in, cnt_rst;
  logic [31:0] cnt_period;
  logic        res_valid;
  logic [31:0] res_period;
  logic [1:0]  res_chan;
  logic        res_timeout, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (!rst && res_valid && res_ready) hs_cnt <= hs_cnt + 1;

  // ch0 toggles every 8 cycles (period 16), ch2 every 20 (period 40)
  always_comb begin
    in_sig    = '0;
    in_sig[0] = ((cyc / 8) % 2) == 1;
    in_sig[2] = ((cyc / 20) % 2) == 1;
  end

  // Counter model: cycles between two rising edges, held until reset.
  logic        prev_m, armed_m;
  logic [31:0] cnt_m;
  always @(posedge clk) begin
    prev_m <= cnt_in;
    if (cnt_rst) begin
      armed_m    <= 1'b0;
      cnt_m      <= '0;
      cnt_period <= '0;
    end else if (cnt_period == 0) begin
      if (cnt_in && !prev_m) begin
        if (!armed_m) begin
          armed_m <= 1'b1;
          cnt_m   <= 1;
        end else begin
          cnt_period <= cnt_m;
        end
      end else if (armed_m) begin
        cnt_m <= cnt_m + 1;
      end
    end
  end

  countgen_scheduler #(
    .CHANNELS(4),
    .SETTLE  (4),
    .TIMEOUT (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .chan_mask  (chan_mask),
    .in         (in_sig),
    .cnt_in     (cnt_in),
    .cnt_rst    (cnt_rst),
    .cnt_period (cnt_period),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_period (res_period),
    .res_chan   (res_chan),
    .res_timeout(res_timeout),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_in_wait(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy && !cnt_rst) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  int          exp_ch [3] = '{0, 2, 0};
  int          exp_pr [3] = '{16, 40, 16};
  bit          ok, stable;
  logic [31:0] p0;
  logic [1:0]  c0;
  int          hs0, t0;

  initial begin
    rst = 1'b1; en = 1'b0; res_ready = 1'b1; chan_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_cnt_rst", cnt_rst, 1);
    chk("rst_period", res_period, 0);
    chk("rst_chan", res_chan, 0);
    chk("rst_tmo", res_timeout, 0);
    rst = 1'b0;

    en = 1'b1;
    repeat (10) @(negedge clk);
    chk("nomask_busy", busy, 0);
    chk("nomask_cnt_rst", cnt_rst, 1);

    chan_mask = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      chk("rr_seen", ok, 1);
      chk("rr_chan", res_chan, exp_ch[k]);
      chk("rr_period", res_period, exp_pr[k]);
      chk("rr_tmo", res_timeout, 0);
    end

    @(negedge clk);
    res_ready = 1'b0;
    wait_valid(ok);
    chk("hold_seen", ok, 1);
    hs0 = hs_cnt; p0 = res_period; c0 = res_chan; stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!res_valid || res_period != p0 || res_chan != c0) stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    chk("hold_chan", c0, 2);
    chk("hold_period", p0, 40);
    chk("hold_no_hs", hs_cnt - hs0, 0);
    res_ready = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("hs_once", hs_cnt - hs0, 1);
    chk("hs_valid_fall", res_valid, 0);
    chk("hs_settle_busy", busy, 1);

    wait_valid(ok);
    chk("endrop_seen", ok, 1);
    chk("endrop_chan", res_chan, 0);
    chk("endrop_period", res_period, 16);
    @(negedge clk);
    chk("endrop_busy", busy, 0);
    chk("endrop_cnt_rst", cnt_rst, 1);
    chk("endrop_valid", res_valid, 0);

    chan_mask = 4'b0100;
    en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok);
      chk("single_seen", ok, 1);
      chk("single_chan", res_chan, 2);
      chk("single_period", res_period, 40);
    end

    wait_in_wait(ok);
    chk("rstw_in_wait", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    chk("rstw_busy", busy, 0);
    chk("rstw_valid", res_valid, 0);
    chk("rstw_cnt_rst", cnt_rst, 1);
    chk("rstw_chan", res_chan, 0);
    chk("rstw_period", res_period, 0);

`ifdef COUNTGEN_SCHED_TIMEOUT_EN
    chan_mask = 4'b0010;
    en = 1'b1;
    wait_in_wait(ok);
    chk("to_in_wait", ok, 1);
    t0 = cyc;
    en = 1'b0;
    wait_valid(ok);
    chk("to_seen", ok, 1);
    chk("to_latency", cyc - t0, 100);
    chk("to_chan", res_chan, 1);
    chk("to_tmo", res_timeout, 1);
    chk("to_period", res_period, 0);
    @(negedge clk);
    chk("to_idle", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
